// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch-stage slice.
package mips_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } pcsel_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ifetch_stage_if.sv
// Fetch-side bus: instruction memory port, IF/ID slot toward decode,
// redirect inputs from decode and the status outputs.
interface ifetch_stage_if #(
    parameter int CNT_W = 16
);
    import mips_pkg::*;

    logic [29:0]      pc;
    logic [31:0]      instr;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [29:0]      if_pc;
    logic [31:0]      if_pc4;
    logic             id_ready;
    pcsel_t           pcsel;
    logic [31:0]      br_offset;
    logic [25:0]      jaddr;
    logic [31:0]      jr_addr;
    logic             misalign;
    logic [CNT_W-1:0] flush_cnt;

    // Fetch stage side.
    modport master (
        output pc, if_valid, if_instr, if_pc, if_pc4, misalign, flush_cnt,
        input  instr, id_ready, pcsel, br_offset, jaddr, jr_addr
    );

    // Memory / decode / environment side.
    modport slave (
        input  pc, if_valid, if_instr, if_pc, if_pc4, misalign, flush_cnt,
        output instr, id_ready, pcsel, br_offset, jaddr, jr_addr
    );

endinterface

// File: rtl/ifetch_stage_pc_next_gen.sv
// Combinational next-PC selection: redirect target, hold, or PC + 1.
// All arithmetic is on 30-bit word addresses and wraps silently.
module pc_next_gen
    import mips_pkg::*;
(
    input  logic [29:0] pc_q_i,
    input  logic [29:0] if_pc_i,
    input  pcsel_t      pcsel_i,
    input  logic [31:0] br_offset_i,
    input  logic [25:0] jaddr_i,
    input  logic [31:0] jr_addr_i,
    input  logic        redirect_i,
    input  logic        hold_i,
    output logic [29:0] next_pc_o,
    output logic        jr_misaligned_o
);

    logic [29:0] if_pc_inc;
    logic [29:0] target;
    logic        unused_br_hi;

    assign if_pc_inc = if_pc_i + 30'd1;

    // Offset bits above the 30-bit word space cannot affect a modulo-2^30 sum.
    assign unused_br_hi = ^br_offset_i[31:30];

    // Redirect target for the instruction sitting in the IF/ID slot.
    always_comb begin
        target = if_pc_inc;
        case (pcsel_i)
            PC_BR:   target = if_pc_inc + br_offset_i[29:0];
            PC_J:    target = {if_pc_inc[29:26], jaddr_i};
            PC_JR:   target = jr_addr_i[31:2];
            default: target = if_pc_inc;
        endcase
    end

    // Redirect wins; a stall freezes the PC; otherwise fetch sequentially.
    always_comb begin
        if (redirect_i)
            next_pc_o = target;
        else if (hold_i)
            next_pc_o = pc_q_i;
        else
            next_pc_o = pc_q_i + 30'd1;
    end

    assign jr_misaligned_o = redirect_i && (pcsel_i == PC_JR) && (jr_addr_i[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: owns the PC, presents it to instruction memory and captures
// the returned word into the IF/ID slot. A taken redirect squashes the slot
// (one bubble); a not-ready decode stalls everything.
module ifetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input logic            clock,
    input logic            reset,
    ifetch_stage_if.master bus
);

    logic [29:0]      pc_q;
    logic [29:0]      pc_d;
    logic             if_valid_q;
    logic [31:0]      if_instr_q;
    logic [29:0]      if_pc_q;
    logic             misalign_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             accept;
    logic             redirect;
    logic             hold;
    logic             jr_misaligned;

    // pcsel only matters for an instruction decode is actually taking.
    assign accept   = if_valid_q & bus.id_ready;
    assign redirect = accept & (bus.pcsel != PC_SEQ);
    assign hold     = if_valid_q & ~bus.id_ready;

    pc_next_gen u_pc_next_gen (
        .pc_q_i          (pc_q),
        .if_pc_i         (if_pc_q),
        .pcsel_i         (bus.pcsel),
        .br_offset_i     (bus.br_offset),
        .jaddr_i         (bus.jaddr),
        .jr_addr_i       (bus.jr_addr),
        .redirect_i      (redirect),
        .hold_i          (hold),
        .next_pc_o       (pc_d),
        .jr_misaligned_o (jr_misaligned)
    );

    // Program counter; memory address comes straight off this register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pc_q <= RESET_PC[31:2];
        else
            pc_q <= pc_d;
    end

    // IF/ID slot: squash on redirect, freeze on stall, else capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= 30'd0;
        end else if (redirect) begin
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
        end else if (!hold) begin
            if_valid_q <= 1'b1;
            if_instr_q <= bus.instr;
            if_pc_q    <= pc_q;
        end
    end

    // Saturating redirect counter and sticky JR-misalignment flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_cnt_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            if (redirect && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (jr_misaligned)
                misalign_q <= 1'b1;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_pc4    = {if_pc_q + 30'd1, 2'b00};
    assign bus.misalign  = misalign_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Fetch stage that sits directly upstream of the instruction memory. It owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into an IF/ID pipeline register for decode.
- Next-PC selection covers sequential, branch, jump and jump-register.
- A valid/ready handshake toward decode provides stall; a taken redirect flushes the fetched slot as a one-bubble penalty.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; bits [1:0] are ignored.
- CNT_W, 16, width of the saturating flush counter.

Ports:
- Clock/reset (already decided): one clock; reset is asynchronous and active-high. Port names are `clock` and `reset`.
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- pc  output  30  word address [31:2] to instruction memory; equals pc_q
- instr  input  32  instruction read combinationally from instruction memory at pc
- if_valid  output  1  IF/ID slot holds a real instruction
- if_instr  output  32  captured instruction; 32'h0 (NOP) when not valid
- if_pc  output  30  word address of if_instr
- if_pc4  output  32  byte address of if_instr plus 4
- id_ready  input  1  decode accepts if_instr this cycle
- pcsel  input  2  redirect select from decode: 0 SEQ, 1 BR, 2 J, 3 JR
- br_offset  input  32  sign-extended branch immediate, in words
- jaddr  input  26  J-type target field
- jr_addr  input  32  register byte address for JR
- misalign  output  1  sticky flag: a JR was taken with jr_addr[1:0] != 0
- flush_cnt  output  CNT_W  count of taken redirects, saturating

Behaviour:
- Reset (asynchronous):
  - pc_q = RESET_PC[31:2]
  - if_valid = 0, if_instr = 0, if_pc = 0
  - misalign = 0, flush_cnt = 0
- Outputs: pc is always pc_q, with zero combinational latency toward the instruction memory. if_pc4 = {if_pc + 1, 2'b00}, combinational from the register.
- Accept condition: accept = if_valid & id_ready. When if_valid = 1 and id_ready = 0, accept = 0 and the stage stalls.
- Redirect condition: redirect = accept & (pcsel != 0). pcsel is ignored when accept = 0, so a stalled branch waits.
- Redirect targets (30-bit word address, modulo 2^30):
  - BR: if_pc + 1 + br_offset[29:0]
  - J: {if_pc4[31:28], jaddr}
  - JR: jr_addr[31:2]
- Per rising edge, evaluated in priority order:
  1. redirect: pc_q <= target; if_valid <= 0; if_instr <= 0; flush_cnt increments unless all ones; if pcsel == JR and jr_addr[1:0] != 0, misalign <= 1.
  2. if_valid & !id_ready (stall): all state holds; pc is unchanged.
  3. otherwise: if_instr <= instr; if_pc <= pc_q; if_valid <= 1; pc_q <= pc_q + 1.
- Latency:
  - The instruction at pc_q appears on if_instr one edge later.
  - The first valid instruction appears on the first edge after reset deasserts.
  - A redirect costs one bubble; the target instruction is valid two edges after the redirect cycle.
- Boundary conditions:
  - Wrap: pc_q = 30'h3FFF_FFFF increments to 0. BR/J arithmetic also wraps with no flag.
  - Stall and redirect together: impossible by construction, since redirect requires id_ready = 1.
  - Bubble slot: when if_valid = 0, the stage always loads (case 3), regardless of id_ready.
  - misalign: cleared only by reset.
  - flush_cnt: holds at 2^CNT_W - 1.
  - Reset mid-stall or mid-redirect returns to reset values immediately; the first fetch after release is from RESET_PC.

Decomposition:
- Shared package mips_pkg holds:
  - pcsel_t enum: PC_SEQ = 2'd0, PC_BR = 2'd1, PC_J = 2'd2, PC_JR = 2'd3
  - constant NOP_INSTR = 32'h0000_0000
- One natural sub-module, pc_next_gen: purely combinational.
  - Inputs: pc_q, if_pc, pcsel, br_offset, jaddr, jr_addr, redirect, hold.
  - Outputs: next_pc and jr_misaligned.
- ifetch_stage keeps the PC register, the IF/ID register, the counter and the flag.

Test Plan:
- Reset then run free, id_ready = 1, memory word n = 32'h1000_0000 + n: pc reads 0, 1, 2, ...; if_instr reads 0x10000000, 0x10000001, ... from the first edge after reset; if_pc4 = 4, 8, ...
- Stall:
  - Stimulus: hold id_ready = 0 for 3 cycles while if_pc = 5.
  - Response: pc stays 6 and if_instr stays mem[5] for all 3 cycles. After release, the next edge loads mem[6] with no lost or duplicate instruction.
- Branch:
  - Stimulus: at if_pc = 10, pcsel = BR, br_offset = -4.
  - Response: pc becomes 7; the next cycle has if_valid = 0 with if_instr = 0; the following cycle has if_instr = mem[7]; flush_cnt = 1.
- Jump and JR:
  - J with if_pc = 30'h1000_0003 and jaddr = 26'h0000020: pc = 30'h1000_0020.
  - JR with jr_addr = 32'h0000_0102: pc = 30'h40 and misalign = 1, which stays set through later sequential fetches.
- Wrap and saturation:
  - Force pc to 30'h3FFF_FFFF: the next pc is 0.
  - Issue 2^CNT_W + 3 redirects: flush_cnt = 16'hFFFF.
- Asynchronous reset during a stall with a pending BR on pcsel: all outputs take reset values immediately, without a clock edge; after release, fetch restarts at RESET_PC[31:2].
